// File: rtl/usb_sie_pkg.sv
// Shared USB SIE receive definitions: byte-stream control codes, STOP status bits,
// PID type encodings, decoder FSM states and the per-type length rule.
package usb_sie_pkg;

  localparam logic [7:0] CTRL_START  = 8'h00;
  localparam logic [7:0] CTRL_STOP   = 8'h01;
  localparam logic [7:0] CTRL_STREAM = 8'h02;

  localparam int STAT_CRC_BIT   = 0;
  localparam int STAT_STUFF_BIT = 1;

  typedef enum logic [1:0] {
    PT_SPECIAL   = 2'b00,
    PT_TOKEN     = 2'b01,
    PT_HANDSHAKE = 2'b10,
    PT_DATA      = 2'b11
  } pid_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PID  = 2'd1,
    ST_BODY = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Body byte count excludes the PID byte; data counts include the two CRC16 bytes.
  function automatic logic length_bad(pid_type_e t, logic [7:0] n);
    case (t)
      PT_TOKEN:     return n != 8'd2;
      PT_HANDSHAKE: return n != 8'd0;
      PT_DATA:      return n < 8'd2;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/usb_rx_packet_decoder_if.sv
// Byte-stream input and decoded-packet output bundle of the USB receive packet decoder.
interface usb_rx_packet_decoder_if;
  logic [7:0]  RxCtrlIn;
  logic [7:0]  RxDataIn;
  logic        RxDataInWEn;
  logic        pktDone;
  logic [3:0]  pid;
  logic        pidError;
  logic        crcError;
  logic        bitStuffError;
  logic        lengthError;
  logic        overflow;
  logic [6:0]  tokenAddr;
  logic [3:0]  tokenEndp;
  logic [10:0] frameNum;
  logic [6:0]  payloadLen;
  logic        bufWEn;
  logic [6:0]  bufAddr;
  logic [7:0]  bufData;

  modport master (
    output RxCtrlIn, RxDataIn, RxDataInWEn,
    input  pktDone, pid, pidError, crcError, bitStuffError, lengthError, overflow,
           tokenAddr, tokenEndp, frameNum, payloadLen, bufWEn, bufAddr, bufData
  );

  modport slave (
    input  RxCtrlIn, RxDataIn, RxDataInWEn,
    output pktDone, pid, pidError, crcError, bitStuffError, lengthError, overflow,
           tokenAddr, tokenEndp, frameNum, payloadLen, bufWEn, bufAddr, bufData
  );
endinterface

// File: rtl/usb_rx_payload_holdback.sv
// Two-byte holdback for data packets: a byte is written only once two newer bytes
// exist, so the trailing CRC16 pair is never written to the payload buffer.
module usb_rx_payload_holdback #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  output logic       buf_wen_o,
  output logic [6:0] buf_addr_o,
  output logic [7:0] buf_data_o,
  output logic [6:0] payload_len_o,
  output logic       overflow_o
);

  localparam logic [6:0] MAX_LEN = 7'(MAX_PAYLOAD);

  logic [1:0] held_q;
  logic [7:0] old_q;
  logic [7:0] new_q;
  logic [6:0] len_q;
  logic       wen_q;
  logic [6:0] addr_q;
  logic [7:0] wdata_q;
  logic       ovf_q;

  // NOTE: the holdback bytes are reset along with the counters so every output reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      held_q  <= 2'd0;
      old_q   <= 8'h00;
      new_q   <= 8'h00;
      len_q   <= 7'd0;
      wen_q   <= 1'b0;
      addr_q  <= 7'd0;
      wdata_q <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let old_q/new_q shift and wdata_q capture the pre-shift oldest byte in one edge.
      wen_q <= 1'b0;
      if (push_i) begin
        if (held_q == 2'd2) begin
          old_q <= new_q;
          new_q <= data_i;
          if (len_q == MAX_LEN) begin
            ovf_q <= 1'b1;
          end else begin
            wen_q   <= 1'b1;
            addr_q  <= len_q;
            wdata_q <= old_q;
            len_q   <= len_q + 7'd1;
          end
        end else begin
          if (held_q == 2'd0) old_q <= data_i;
          else                new_q <= data_i;
          held_q <= held_q + 2'd1;
        end
      end
    end
  end

  assign buf_wen_o     = wen_q;
  assign buf_addr_o    = addr_q;
  assign buf_data_o    = wdata_q;
  assign payload_len_o = len_q;
  assign overflow_o    = ovf_q;

endmodule

// File: rtl/usb_rx_packet_decoder.sv
// USB receive packet decoder: frames START/STREAM/STOP byte strobes into packets,
// checks PID and length, decodes token/SOF fields and forwards data payload bytes.
module usb_rx_packet_decoder
  import usb_sie_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64
) (
  input logic                     clk,
  input logic                     rst,
  usb_rx_packet_decoder_if.slave  bus
);

  state_e     state_q, state_d;
  logic       pkt_done;
  logic [3:0] pid_q;
  logic       pid_error_q;
  logic       crc_error_q;
  logic       stuff_error_q;
  logic       length_error_q;
  logic [6:0] token_addr_q;
  logic [3:0] token_endp_q;
  logic [10:0] frame_num_q;
  logic [7:0] byte_cnt_q;
  logic [7:0] b1_q;
  logic [2:0] b2_q;
  pid_type_e  pid_type;

  logic is_start, is_stop, is_stream, push;

  assign is_start  = bus.RxDataInWEn && (bus.RxCtrlIn == CTRL_START);
  assign is_stop   = bus.RxDataInWEn && (bus.RxCtrlIn == CTRL_STOP);
  assign is_stream = bus.RxDataInWEn && (bus.RxCtrlIn == CTRL_STREAM);
  assign pid_type  = pid_type_e'(pid_q[1:0]);
  assign push      = is_stream && (state_q == ST_BODY) && (pid_type == PT_DATA);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // START is honoured in every state, so DONE behaves exactly like IDLE for a new strobe.
  always_comb begin
    // NOTE: assigning a default first keeps this combinational block free of inferred latches.
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = is_start ? ST_PID : ST_IDLE;
      ST_PID: begin
        if (is_start)       state_d = ST_PID;
        else if (is_stream) state_d = ST_BODY;
        else if (is_stop)   state_d = ST_DONE;
      end
      ST_BODY: begin
        if (is_start)     state_d = ST_PID;
        else if (is_stop) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pkt_done = 1'b0;
    if (state_q == ST_DONE) pkt_done = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || is_start) begin
      pid_q          <= 4'h0;
      pid_error_q    <= 1'b0;
      crc_error_q    <= 1'b0;
      stuff_error_q  <= 1'b0;
      length_error_q <= 1'b0;
      token_addr_q   <= 7'd0;
      token_endp_q   <= 4'd0;
      frame_num_q    <= 11'd0;
      byte_cnt_q     <= 8'd0;
      b1_q           <= 8'h00;
      b2_q           <= 3'd0;
    end else begin
      if (state_q == ST_PID && is_stream) begin
        pid_q       <= bus.RxDataIn[3:0];
        pid_error_q <= bus.RxDataIn[7:4] != ~bus.RxDataIn[3:0];
      end
      if (state_q == ST_BODY && is_stream) begin
        byte_cnt_q <= (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
        if (byte_cnt_q == 8'd0) b1_q <= bus.RxDataIn;
        if (byte_cnt_q == 8'd1) b2_q <= bus.RxDataIn[2:0];
      end
      if (is_stop && (state_q == ST_PID || state_q == ST_BODY)) begin
        crc_error_q   <= bus.RxDataIn[STAT_CRC_BIT];
        stuff_error_q <= bus.RxDataIn[STAT_STUFF_BIT];
        if (state_q == ST_PID) begin
          length_error_q <= 1'b1;
        end else begin
          length_error_q <= length_bad(pid_type, byte_cnt_q);
          if (pid_type == PT_TOKEN) begin
            token_addr_q <= b1_q[6:0];
            token_endp_q <= {b2_q, b1_q[7]};
            frame_num_q  <= {b2_q, b1_q};
          end
        end
      end
    end
  end

  logic       hb_wen;
  logic [6:0] hb_addr;
  logic [7:0] hb_data;
  logic [6:0] hb_len;
  logic       hb_ovf;

  usb_rx_payload_holdback #(.MAX_PAYLOAD(MAX_PAYLOAD)) u_holdback (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (is_start),
    .push_i        (push),
    .data_i        (bus.RxDataIn),
    .buf_wen_o     (hb_wen),
    .buf_addr_o    (hb_addr),
    .buf_data_o    (hb_data),
    .payload_len_o (hb_len),
    .overflow_o    (hb_ovf)
  );

  assign bus.pktDone       = pkt_done;
  assign bus.pid           = pid_q;
  assign bus.pidError      = pid_error_q;
  assign bus.crcError      = crc_error_q;
  assign bus.bitStuffError = stuff_error_q;
  assign bus.lengthError   = length_error_q;
  assign bus.overflow      = hb_ovf;
  assign bus.tokenAddr     = token_addr_q;
  assign bus.tokenEndp     = token_endp_q;
  assign bus.frameNum      = frame_num_q;
  assign bus.payloadLen    = hb_len;
  assign bus.bufWEn        = hb_wen;
  assign bus.bufAddr       = hb_addr;
  assign bus.bufData       = hb_data;

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// Directed self-checking bench for usb_rx_packet_decoder with hand-computed expectations.
module tb_usb_rx_packet_decoder;

  localparam logic [7:0] START  = 8'h00;
  localparam logic [7:0] STOP   = 8'h01;
  localparam logic [7:0] STREAM = 8'h02;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  int         wr_cnt = 0;
  int         done_cnt = 0;
  logic [6:0] wr_addr [256];
  logic [7:0] wr_data [256];

  usb_rx_packet_decoder_if bus_if ();

  usb_rx_packet_decoder #(.MAX_PAYLOAD(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_if.bufWEn === 1'b1) begin
      if (wr_cnt < 256) begin
        wr_addr[wr_cnt] = bus_if.bufAddr;
        wr_data[wr_cnt] = bus_if.bufData;
      end
      wr_cnt++;
    end
    if (bus_if.pktDone === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic send(input logic [7:0] ctrl, input logic [7:0] data);
    @(negedge clk);
    bus_if.RxCtrlIn    = ctrl;
    bus_if.RxDataIn    = data;
    bus_if.RxDataInWEn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus_if.RxDataInWEn = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.RxCtrlIn = START; bus_if.RxDataIn = 8'h00; bus_if.RxDataInWEn = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus_if.pktDone !== 1'b0) begin errors++; $display("FAIL rst_pktDone: got %b want 0", bus_if.pktDone); end
    checks++; if (bus_if.pid !== 4'h0) begin errors++; $display("FAIL rst_pid: got %h want 0", bus_if.pid); end
    checks++; if ({bus_if.pidError, bus_if.crcError, bus_if.bitStuffError, bus_if.lengthError, bus_if.overflow} !== 5'b0) begin
      errors++; $display("FAIL rst_flags: got %b want 00000", {bus_if.pidError, bus_if.crcError, bus_if.bitStuffError, bus_if.lengthError, bus_if.overflow}); end
    checks++; if ({bus_if.tokenAddr, bus_if.tokenEndp, bus_if.frameNum} !== 22'd0) begin
      errors++; $display("FAIL rst_fields: got %h want 0", {bus_if.tokenAddr, bus_if.tokenEndp, bus_if.frameNum}); end
    checks++; if ({bus_if.bufWEn, bus_if.bufAddr, bus_if.bufData, bus_if.payloadLen} !== 23'd0) begin
      errors++; $display("FAIL rst_buf: got %h want 0", {bus_if.bufWEn, bus_if.bufAddr, bus_if.bufData, bus_if.payloadLen}); end
    @(negedge clk);
    rst = 1'b0;
    bus_if.RxDataInWEn = 1'b0;
    // START held during reset must not have been taken: STREAM/STOP are ignored in IDLE
    send(STREAM, 8'hE1);
    send(STOP, 8'h03);
    checks++; if (bus_if.pktDone !== 1'b0) begin errors++; $display("FAIL rst_idle_stop: pktDone got %b want 0", bus_if.pktDone); end
    checks++; if (bus_if.pid !== 4'h0 || bus_if.crcError !== 1'b0) begin
      errors++; $display("FAIL rst_idle_fields: pid %h crc %b want 0 0", bus_if.pid, bus_if.crcError); end
    idle(1);
  endtask

  task automatic test_token();
    int base_wr = wr_cnt;
    int base_done = done_cnt;
    send(START, 8'h00);
    send(STREAM, 8'hE1);
    send(STREAM, 8'h85);
    send(STREAM, 8'h11);
    send(STOP, 8'h00);
    checks++; if (bus_if.pktDone !== 1'b1) begin errors++; $display("FAIL token_pktDone: got %b want 1", bus_if.pktDone); end
    checks++; if (bus_if.pid !== 4'h1) begin errors++; $display("FAIL token_pid: got %h want 1", bus_if.pid); end
    checks++; if (bus_if.tokenAddr !== 7'h05) begin errors++; $display("FAIL token_addr: got %h want 05", bus_if.tokenAddr); end
    checks++; if (bus_if.tokenEndp !== 4'h3) begin errors++; $display("FAIL token_endp: got %h want 3", bus_if.tokenEndp); end
    checks++; if (bus_if.frameNum !== 11'h185) begin errors++; $display("FAIL token_frame: got %h want 185", bus_if.frameNum); end
    checks++; if ({bus_if.pidError, bus_if.crcError, bus_if.bitStuffError, bus_if.lengthError, bus_if.overflow} !== 5'b0) begin
      errors++; $display("FAIL token_flags: got %b want 00000", {bus_if.pidError, bus_if.crcError, bus_if.bitStuffError, bus_if.lengthError, bus_if.overflow}); end
    idle(2);
    checks++; if (bus_if.pktDone !== 1'b0 || done_cnt - base_done != 1) begin
      errors++; $display("FAIL token_pulse: pktDone %b pulses %0d want 0 1", bus_if.pktDone, done_cnt - base_done); end
    checks++; if (bus_if.pid !== 4'h1 || bus_if.tokenAddr !== 7'h05) begin
      errors++; $display("FAIL token_hold: pid %h addr %h want 1 05", bus_if.pid, bus_if.tokenAddr); end
    checks++; if (wr_cnt - base_wr != 0) begin errors++; $display("FAIL token_nowrite: got %0d writes want 0", wr_cnt - base_wr); end
  endtask

  task automatic test_data0();
    int base_wr = wr_cnt;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'hAA; exp_d[1] = 8'hBB; exp_d[2] = 8'hCC;
    send(START, 8'h00);
    send(STREAM, 8'hC3);
    send(STREAM, 8'hAA);
    send(STREAM, 8'hBB);
    checks++; if (bus_if.bufWEn !== 1'b0) begin errors++; $display("FAIL data0_early_wen: got %b want 0", bus_if.bufWEn); end
    send(STREAM, 8'hCC);
    checks++; if (bus_if.bufWEn !== 1'b1 || bus_if.bufData !== 8'hAA || bus_if.bufAddr !== 7'd0) begin
      errors++; $display("FAIL data0_first_write: wen %b addr %h data %h want 1 00 aa", bus_if.bufWEn, bus_if.bufAddr, bus_if.bufData); end
    send(STREAM, 8'h12);
    send(STREAM, 8'h34);
    send(STOP, 8'h00);
    checks++; if (bus_if.pktDone !== 1'b1 || bus_if.pid !== 4'h3) begin
      errors++; $display("FAIL data0_done: pktDone %b pid %h want 1 3", bus_if.pktDone, bus_if.pid); end
    checks++; if (bus_if.payloadLen !== 7'd3 || bus_if.lengthError !== 1'b0 || bus_if.overflow !== 1'b0) begin
      errors++; $display("FAIL data0_len: len %0d lenErr %b ovf %b want 3 0 0", bus_if.payloadLen, bus_if.lengthError, bus_if.overflow); end
    idle(3);
    checks++; if (wr_cnt - base_wr != 3) begin errors++; $display("FAIL data0_count: got %0d writes want 3", wr_cnt - base_wr); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (wr_addr[base_wr + k] !== 7'(k) || wr_data[base_wr + k] !== exp_d[k]) begin
        errors++; $display("FAIL data0_write%0d: addr %h data %h want %h %h", k, wr_addr[base_wr + k], wr_data[base_wr + k], 7'(k), exp_d[k]);
      end
    end
  endtask

  task automatic test_handshake();
    send(START, 8'h00);
    send(STREAM, 8'hD2);
    send(STOP, 8'h01);
    checks++; if (bus_if.pktDone !== 1'b1 || bus_if.pid !== 4'h2) begin
      errors++; $display("FAIL ack_done: pktDone %b pid %h want 1 2", bus_if.pktDone, bus_if.pid); end
    checks++; if (bus_if.crcError !== 1'b1 || bus_if.lengthError !== 1'b0 || bus_if.pidError !== 1'b0 || bus_if.bitStuffError !== 1'b0) begin
      errors++; $display("FAIL ack_flags: crc %b len %b pid %b stuff %b want 1 0 0 0", bus_if.crcError, bus_if.lengthError, bus_if.pidError, bus_if.bitStuffError); end
    idle(1);
    send(START, 8'h00);
    checks++; if (bus_if.crcError !== 1'b0 || bus_if.pid !== 4'h0) begin
      errors++; $display("FAIL start_clears: crc %b pid %h want 0 0", bus_if.crcError, bus_if.pid); end
    send(STREAM, 8'hD3);
    send(STOP, 8'h02);
    checks++; if (bus_if.pidError !== 1'b1 || bus_if.pid !== 4'h3) begin
      errors++; $display("FAIL piderr: pidError %b pid %h want 1 3", bus_if.pidError, bus_if.pid); end
    checks++; if (bus_if.lengthError !== 1'b1 || bus_if.bitStuffError !== 1'b1 || bus_if.crcError !== 1'b0) begin
      errors++; $display("FAIL short_data: len %b stuff %b crc %b want 1 1 0", bus_if.lengthError, bus_if.bitStuffError, bus_if.crcError); end
    idle(1);
    send(START, 8'h00);
    send(STOP, 8'h00);
    checks++; if (bus_if.pktDone !== 1'b1 || bus_if.lengthError !== 1'b1) begin
      errors++; $display("FAIL stop_in_pid: pktDone %b len %b want 1 1", bus_if.pktDone, bus_if.lengthError); end
    idle(1);
  endtask

  task automatic test_abort();
    int base_wr = wr_cnt;
    int base_done = done_cnt;
    send(START, 8'h00);
    send(STREAM, 8'hC3);
    send(STREAM, 8'hAA);
    send(STREAM, 8'hBB);
    send(START, 8'h00);
    send(STREAM, 8'hD2);
    send(STOP, 8'h00);
    idle(2);
    checks++; if (done_cnt - base_done != 1) begin errors++; $display("FAIL abort_pulses: got %0d want 1", done_cnt - base_done); end
    checks++; if (bus_if.pid !== 4'h2 || bus_if.lengthError !== 1'b0 || bus_if.payloadLen !== 7'd0) begin
      errors++; $display("FAIL abort_ack: pid %h len %b plen %0d want 2 0 0", bus_if.pid, bus_if.lengthError, bus_if.payloadLen); end
    checks++; if (wr_cnt - base_wr != 0) begin errors++; $display("FAIL abort_nowrite: got %0d writes want 0", wr_cnt - base_wr); end
  endtask

  task automatic test_back_to_back();
    int base_done = done_cnt;
    send(START, 8'h00);
    send(STREAM, 8'hA5);
    send(STREAM, 8'h3A);
    send(STREAM, 8'h06);
    send(STOP, 8'h00);
    send(START, 8'h00);
    checks++; if (bus_if.pid !== 4'h0 || bus_if.tokenAddr !== 7'd0) begin
      errors++; $display("FAIL b2b_start_in_done: pid %h addr %h want 0 00", bus_if.pid, bus_if.tokenAddr); end
    send(STREAM, 8'h5A);
    send(STOP, 8'h00);
    checks++; if (bus_if.pktDone !== 1'b1 || bus_if.pid !== 4'hA || bus_if.lengthError !== 1'b0) begin
      errors++; $display("FAIL b2b_second: pktDone %b pid %h len %b want 1 a 0", bus_if.pktDone, bus_if.pid, bus_if.lengthError); end
    idle(2);
    checks++; if (done_cnt - base_done != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", done_cnt - base_done); end
  endtask

  task automatic test_overflow();
    int base_wr = wr_cnt;
    int bad = 0;
    send(START, 8'h00);
    send(STREAM, 8'h4B);
    for (int k = 0; k < 68; k++) send(STREAM, 8'(k));
    send(STOP, 8'h00);
    checks++; if (bus_if.pktDone !== 1'b1 || bus_if.pid !== 4'hB || bus_if.pidError !== 1'b0) begin
      errors++; $display("FAIL ovf_done: pktDone %b pid %h pidErr %b want 1 b 0", bus_if.pktDone, bus_if.pid, bus_if.pidError); end
    checks++; if (bus_if.overflow !== 1'b1 || bus_if.payloadLen !== 7'd64 || bus_if.lengthError !== 1'b0) begin
      errors++; $display("FAIL ovf_flags: ovf %b len %0d lenErr %b want 1 64 0", bus_if.overflow, bus_if.payloadLen, bus_if.lengthError); end
    idle(2);
    checks++; if (wr_cnt - base_wr != 64) begin errors++; $display("FAIL ovf_count: got %0d writes want 64", wr_cnt - base_wr); end
    for (int k = 0; k < 64; k++)
      if (wr_addr[base_wr + k] !== 7'(k) || wr_data[base_wr + k] !== 8'(k)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ovf_contents: got %0d bad entries want 0", bad); end
  endtask

  task automatic test_reset_mid();
    int base_wr = wr_cnt;
    int base_done = done_cnt;
    send(START, 8'h00);
    send(STREAM, 8'hC3);
    send(STREAM, 8'h11);
    send(STREAM, 8'h22);
    send(STREAM, 8'h33);
    send(STREAM, 8'h44);
    checks++; if (bus_if.bufWEn !== 1'b1 || bus_if.bufData !== 8'h22) begin
      errors++; $display("FAIL rmid_prewrite: wen %b data %h want 1 22", bus_if.bufWEn, bus_if.bufData); end
    @(negedge clk);
    rst = 1'b1;
    bus_if.RxCtrlIn = STREAM; bus_if.RxDataIn = 8'h55; bus_if.RxDataInWEn = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus_if.bufWEn !== 1'b0 || bus_if.payloadLen !== 7'd0 || bus_if.pid !== 4'h0 || bus_if.bufData !== 8'h00) begin
      errors++; $display("FAIL rmid_outputs: wen %b plen %0d pid %h data %h want 0 0 0 00", bus_if.bufWEn, bus_if.payloadLen, bus_if.pid, bus_if.bufData); end
    @(negedge clk);
    rst = 1'b0;
    bus_if.RxDataInWEn = 1'b0;
    send(STREAM, 8'h66);
    send(STOP, 8'h00);
    idle(2);
    checks++; if (wr_cnt - base_wr != 2) begin errors++; $display("FAIL rmid_writes: got %0d want 2", wr_cnt - base_wr); end
    checks++; if (done_cnt - base_done != 0) begin errors++; $display("FAIL rmid_nodone: got %0d pulses want 0", done_cnt - base_done); end
  endtask

  initial begin
    bus_if.RxCtrlIn    = 8'h00;
    bus_if.RxDataIn    = 8'h00;
    bus_if.RxDataInWEn = 1'b0;
    test_reset();
    test_token();
    test_data0();
    test_handshake();
    test_abort();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_packet_decoder.md
USB_RX_PACKET_DECODER -- requirements
Module: usb_rx_packet_decoder

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 64, maximum data-packet payload bytes stored (CRC16 excluded).
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- RxCtrlIn  in  8  byte-stream control code from the SIE receive path.
- RxDataIn  in  8  byte, or status on STOP.
- RxDataInWEn  in  1  1-cycle strobe qualifying RxCtrlIn/RxDataIn; no backpressure.
- pktDone  out  1  1-cycle pulse: packet fields/flags valid.
- pid  out  4  received PID[3:0].
- pidError  out  1  PID check nibble mismatch.
- crcError  out  1  STOP status bit0.
- bitStuffError  out  1  STOP status bit1.
- lengthError  out  1  byte count illegal for PID type.
- overflow  out  1  payload exceeded MAX_PAYLOAD.
- tokenAddr  out  7  token address.
- tokenEndp  out  4  token endpoint.
- frameNum  out  11  SOF frame number.
- payloadLen  out  7  data bytes written to buffer.
- bufWEn  out  1  payload write strobe.
- bufAddr  out  7  payload write address.
- bufData  out  8  payload byte.

Function
REQ-003 Control codes SHALL be START=8'h00, STOP=8'h01, STREAM=8'h02; other codes ignored.
REQ-004 FSM states IDLE, PID, BODY, DONE; reset state IDLE.
REQ-005 IDLE: START -> PID; STREAM/STOP ignored.
REQ-006 PID: first STREAM latches pid=RxDataIn[3:0]; pidError=(RxDataIn[7:4]!=~RxDataIn[3:0]); -> BODY. STOP in PID -> DONE with lengthError=1.
REQ-007 BODY: each STREAM increments byteCount (8-bit, saturating at 255); STOP -> DONE.
REQ-008 START in PID or BODY SHALL abort silently (no pktDone) and restart in PID with all counters/flags cleared.
REQ-009 DONE lasts exactly one cycle, pktDone=1, then IDLE; a strobe arriving in DONE SHALL be processed as in IDLE.
REQ-010 On STOP, crcError=RxDataIn[0], bitStuffError=RxDataIn[1] latched.
REQ-011 PID type by pid[1:0]: 01 token, 11 data, 10 handshake, 00 special (no length check).
REQ-012 Token: body bytes b1,b2; tokenAddr=b1[6:0]; tokenEndp={b2[2:0],b1[7]}; frameNum={b2[2:0],b1}; lengthError if byteCount!=2.
REQ-013 Handshake: lengthError if byteCount!=0.
REQ-014 Data: 2-entry holdback register; when a STREAM byte arrives with 2 held, oldest byte written (bufWEn=1, bufAddr=payloadLen, bufData=oldest) in the same cycle's registered output, i.e. 1 cycle after strobe; held 2 bytes at STOP are CRC16 and discarded.
REQ-015 Data: lengthError if byteCount<2; writes when payloadLen==MAX_PAYLOAD suppressed and overflow=1.
REQ-016 Non-data packets SHALL never assert bufWEn.
REQ-017 Output fields and flags SHALL hold from pktDone until next START; cleared at START.
REQ-018 Throughput: consecutive-cycle strobes accepted with no loss.

Reset
REQ-019 rst SHALL force IDLE and all outputs to 0 next edge; rst mid-packet discards packet with no pktDone and no further bufWEn.
REQ-020 Reset overrides any simultaneous RxDataInWEn.

Structure
REQ-021 Control codes, STOP status bit positions, PID type encodings, FSM state encoding SHALL live in shared package usb_sie_pkg.
REQ-022 Holdback/buffer-write logic SHALL be sub-module usb_rx_payload_holdback; FSM and field decode in top.

Verification
REQ-023 Token: START, 8'hE1, 8'h85, 8'h11, STOP(8'h00) -> pid=1, tokenAddr=7'h05, tokenEndp=4'h3, no flags, pktDone 1 cycle after STOP.
REQ-024 DATA0 3 payload bytes 8'hAA,8'hBB,8'hCC + 2 CRC, back-to-back strobes -> bufWEn 3 times addr 0..2 data AA,BB,CC, payloadLen=3, CRC never written.
REQ-025 ACK 8'hD2 then STOP(8'h01) -> pid=2, crcError=1, lengthError=0; PID 8'hD3 -> pidError=1.
REQ-026 DATA1 with 66 payload bytes, MAX_PAYLOAD=64 -> 64 writes, overflow=1, payloadLen=64.
REQ-027 START mid-BODY then full ACK -> single pktDone for ACK; rst mid-data -> no pktDone, bufWEn stops next cycle, outputs 0.
